// File: rtl/fa16_seq_pkg.sv
// ---------------------------------------------------------------------------
// fa16_seq_pkg
//
// Shared types and constants for the fa16_rev sequencer slice.
//   WIDTH        - operand width of the reversible adder (fixed at 16)
//   seq_state_e  - sequencer FSM states
//   fwd_res_t    - forward-direction adder outputs captured for the
//                  backward (uncompute) pass
// ---------------------------------------------------------------------------
package fa16_seq_pkg;

  localparam int WIDTH = 16;

  // IDLE: waiting for a request
  // FWD : adder driven forward, settling
  // OUT : result offered downstream
  // BWD : adder driven backward, settling, then round-trip compare
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    OUT  = 2'd2,
    BWD  = 2'd3
  } seq_state_e;

  // Everything the forward pass produces, which is exactly what must be
  // pushed back in to recover the operands.
  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a_b;
    logic             c0_b;
    logic             c15;
  } fwd_res_t;

endpackage

// File: rtl/fa16_seq_chk.sv
// ---------------------------------------------------------------------------
// fa16_seq_chk
//
// Purely combinational round-trip checker. Compares the operands recovered
// by the backward pass of fa16_rev against the operands that were latched
// when the request was accepted. The ancilla line r_z must come back as 0.
//
// Ports:
//   r_a, r_b   in  WIDTH  recovered operands
//   r_c0_f     in  1      recovered carry-in
//   r_z        in  1      recovered ancilla (expected 0)
//   op_a, op_b in  WIDTH  latched original operands
//   op_c0      in  1      latched original carry-in
//   mismatch   out 1      1 when any recovered bit differs
// ---------------------------------------------------------------------------
module fa16_seq_chk
  import fa16_seq_pkg::*;
(
  input  logic [WIDTH-1:0] r_a,
  input  logic [WIDTH-1:0] r_b,
  input  logic             r_c0_f,
  input  logic             r_z,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_c0,
  output logic             mismatch
);

  logic a_diff;
  logic b_diff;
  logic c0_diff;
  logic z_diff;

  assign a_diff  = (r_a != op_a);
  assign b_diff  = (r_b != op_b);
  assign c0_diff = (r_c0_f != op_c0);
  assign z_diff  = (r_z != 1'b0);

  assign mismatch = a_diff | b_diff | c0_diff | z_diff;

endmodule

// File: rtl/fa16_rev_seq.sv
// ---------------------------------------------------------------------------
// fa16_rev_seq
//
// Sequencer sitting directly in front of the reversible adder fa16_rev.
// A request (a, b, c0) is accepted over valid/ready, the adder is driven
// forward for SETTLE_CYC cycles, the sum/carry is handed downstream over
// valid/ready, and then the captured forward outputs are driven back
// through the adder for SETTLE_CYC cycles. The recovered operands are
// compared with the originals; any difference sets the sticky chk_err.
//
// Parameters:
//   SETTLE_CYC  cycles the adder is held in each direction (1..15)
//   WIDTH       operand width, must be 16
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready combinational)
//   in_a, in_b, in_c0     request operands
//   res_valid/res_ready   result handshake
//   res_sum, res_cout     registered result
//   chk_err, err_clr      sticky round-trip mismatch flag and its clear
//   op_cnt                completed round-trips (wraps)
//   dir                   adder direction, 0 = forward, 1 = backward
//   f_a,f_b,f_c0_f,f_z    forward drive into the adder
//   f_s,f_a_b,f_c0_b,f_c15 forward results from the adder
//   r_s,r_a_b,r_c0_b,r_c15 backward drive into the adder
//   r_a,r_b,r_c0_f,r_z    operands recovered by the backward pass
// ---------------------------------------------------------------------------
module fa16_rev_seq
  import fa16_seq_pkg::seq_state_e;
  import fa16_seq_pkg::fwd_res_t;
  import fa16_seq_pkg::IDLE;
  import fa16_seq_pkg::FWD;
  import fa16_seq_pkg::OUT;
  import fa16_seq_pkg::BWD;
#(
  parameter int SETTLE_CYC = 2,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c0,

  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,

  output logic             chk_err,
  input  logic             err_clr,
  output logic [15:0]      op_cnt,

  output logic             dir,

  output logic [WIDTH-1:0] f_a,
  output logic [WIDTH-1:0] f_b,
  output logic             f_c0_f,
  output logic             f_z,
  input  logic [WIDTH-1:0] f_s,
  input  logic [WIDTH-1:0] f_a_b,
  input  logic             f_c0_b,
  input  logic             f_c15,

  output logic [WIDTH-1:0] r_s,
  output logic [WIDTH-1:0] r_a_b,
  output logic             r_c0_b,
  output logic             r_c15,
  input  logic [WIDTH-1:0] r_a,
  input  logic [WIDTH-1:0] r_b,
  input  logic             r_c0_f,
  input  logic             r_z
);

  // The adder this drives is a fixed 16-bit part, and the settle counter
  // is 4 bits wide; reject anything else at elaboration.
  generate
    if (WIDTH != fa16_seq_pkg::WIDTH) begin : g_bad_width
      $error("fa16_rev_seq: WIDTH must be 16");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("fa16_rev_seq: SETTLE_CYC must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  seq_state_e       state;
  logic [3:0]       settle_cnt;
  logic             settle_last;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_c0;

  fwd_res_t         fwd_res;

  logic             mismatch;
  logic             chk_fire;

  // Ready only while idle, and never while reset is held so a request
  // cannot be "accepted" on an edge that the reset is about to discard.
  assign in_ready = (state == IDLE) & ~rst;

  assign settle_last = (settle_cnt == SETTLE_LAST);

  // The compare is only meaningful on the final backward settle cycle;
  // outside of it the backward outputs are not being driven.
  assign chk_fire = (state == BWD) & settle_last;

  fa16_seq_chk u_chk (
    .r_a      (r_a),
    .r_b      (r_b),
    .r_c0_f   (r_c0_f),
    .r_z      (r_z),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_c0    (op_c0),
    .mismatch (mismatch)
  );

  // Main sequencer. The forward and backward drive registers only change
  // on the transition into their own phase and otherwise hold, since the
  // adder tristates whichever side is not selected by dir.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      dir        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_c0      <= 1'b0;
      fwd_res    <= '0;
      f_a        <= '0;
      f_b        <= '0;
      f_c0_f     <= 1'b0;
      f_z        <= 1'b0;
      r_s        <= '0;
      r_a_b      <= '0;
      r_c0_b     <= 1'b0;
      r_c15      <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_valid  <= 1'b0;
      op_cnt     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a       <= in_a;
            op_b       <= in_b;
            op_c0      <= in_c0;
            f_a        <= in_a;
            f_b        <= in_b;
            f_c0_f     <= in_c0;
            f_z        <= 1'b0;
            dir        <= 1'b0;
            settle_cnt <= 4'd0;
            state      <= FWD;
          end
        end

        FWD: begin
          if (settle_last) begin
            fwd_res.s    <= f_s;
            fwd_res.a_b  <= f_a_b;
            fwd_res.c0_b <= f_c0_b;
            fwd_res.c15  <= f_c15;
            res_sum      <= f_s;
            res_cout     <= f_c15;
            res_valid    <= 1'b1;
            settle_cnt   <= 4'd0;
            state        <= OUT;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        OUT: begin
          // res_valid is always 1 here, so res_ready alone completes
          // the handshake. Flip the adder in the same edge so the
          // backward window starts immediately.
          if (res_ready) begin
            res_valid  <= 1'b0;
            r_s        <= fwd_res.s;
            r_a_b      <= fwd_res.a_b;
            r_c0_b     <= fwd_res.c0_b;
            r_c15      <= fwd_res.c15;
            dir        <= 1'b1;
            settle_cnt <= 4'd0;
            state      <= BWD;
          end
        end

        BWD: begin
          if (settle_last) begin
            op_cnt     <= op_cnt + 16'd1;
            dir        <= 1'b0;
            settle_cnt <= 4'd0;
            state      <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flag. A mismatch detected on the same edge as err_clr
  // takes priority so a fresh error is never lost to a stale clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if (chk_fire && mismatch) begin
      chk_err <= 1'b1;
    end else if (err_clr) begin
      chk_err <= 1'b0;
    end
  end

endmodule
